// File: rtl/pe_dot_ctrl.sv
// Sequencing controller for one dot-product job on the 32-lane int16 PE:
// streams buffer read addresses, tags operand beats and gates the accumulator.
module pe_dot_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int LEN_W    = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] neuron_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic              pause,
  output logic              busy,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_addr,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_addr,
  output logic              pe_vld,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SR_W  = PIPE_LAT + 1;
  localparam int CNT_W = 5;

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   drain_cnt;
  logic [SR_W-1:0]    vld_sr;

  // Job sequencing; the first beat is issued straight from the acceptance edge
  // so that read enable appears one cycle after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      nram_rd_en <= 1'b0;
      nram_addr  <= '0;
      wram_addr  <= '0;
      acc_clr    <= 1'b0;
      done       <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            acc_clr <= 1'b1;
            if (vec_len != '0) begin
              nram_rd_en <= 1'b1;
              nram_addr  <= neuron_base;
              wram_addr  <= weight_base;
              remaining  <= vec_len - LEN_W'(1);
              state      <= S_ISSUE;
            end else begin
              drain_cnt <= CNT_W'(PIPE_LAT);
              state     <= S_DRAIN;
            end
          end
        end
        S_ISSUE: begin
          // remaining counts beats still to issue after the one now on the bus
          if (remaining == '0) begin
            nram_rd_en <= 1'b0;
            drain_cnt  <= CNT_W'(PIPE_LAT);
            state      <= S_DRAIN;
          end else if (pause) begin
            nram_rd_en <= 1'b0;
          end else begin
            nram_rd_en <= 1'b1;
            nram_addr  <= nram_addr + ADDR_W'(1);
            wram_addr  <= wram_addr + ADDR_W'(1);
            remaining  <= remaining - LEN_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          nram_rd_en <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Beat-valid pipeline: bit 0 covers the buffer read, the rest the PE latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[SR_W-2:0], nram_rd_en};
    end
  end

  assign wram_rd_en = nram_rd_en;
  assign pe_vld     = vld_sr[0];
  assign acc_en     = vld_sr[SR_W-1];

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// Randomized self-checking bench for pe_dot_ctrl against a cycle-timeline
// model built from the job timing rules (issue slots, fixed latencies).
module tb_pe_dot_ctrl;
  localparam int PL   = 2;
  localparam int MAXC = 63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] vec_len = 16'd0;
  logic [7:0]  neuron_base = 8'd0;
  logic [7:0]  weight_base = 8'd0;
  logic        pause = 1'b0;
  logic        busy, nram_rd_en, wram_rd_en, pe_vld, acc_clr, acc_en, done;
  logic [7:0]  nram_addr, wram_addr;

  int n_cmp = 0;
  int n_fail = 0;

  // per-cycle control vector: {busy, nram_rd_en, wram_rd_en, pe_vld, acc_clr, acc_en, done}
  logic [6:0] obs_ctrl [0:MAXC];
  logic [6:0] exp_ctrl [0:MAXC];
  logic [7:0] obs_na [0:MAXC];
  logic [7:0] obs_wa [0:MAXC];
  logic [7:0] exp_na [0:MAXC];
  logic [7:0] exp_wa [0:MAXC];
  int         obs_done_cyc;
  int         exp_done;

  pe_dot_ctrl #(.ADDR_W(8), .LEN_W(16), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .neuron_base(neuron_base), .weight_base(weight_base), .pause(pause),
    .busy(busy), .nram_rd_en(nram_rd_en), .nram_addr(nram_addr),
    .wram_rd_en(wram_rd_en), .wram_addr(wram_addr), .pe_vld(pe_vld),
    .acc_clr(acc_clr), .acc_en(acc_en), .done(done)
  );

  always #5 clk = ~clk;

  // Reference timeline: beat j issues in the j-th free slot (slot 1 is never
  // paused); everything else is a fixed offset from those slots.
  task automatic model_job(input int n, input logic [7:0] nb, input logic [7:0] wb,
                           input logic [63:0] pm, input int rst_cyc);
    bit rd [0:MAXC];
    int issued, last;
    issued = 0;
    last = 0;
    for (int k = 0; k <= MAXC; k++) begin
      rd[k] = 1'b0;
      exp_na[k] = 8'd0;
      exp_wa[k] = 8'd0;
    end
    for (int k = 1; k <= MAXC; k++) begin
      if (issued < n && (k == 1 || !pm[k])) begin
        rd[k] = 1'b1;
        exp_na[k] = nb + 8'(issued);
        exp_wa[k] = wb + 8'(issued);
        issued++;
        last = k;
      end
    end
    exp_done = last + 2 + PL;
    for (int k = 0; k <= MAXC; k++) begin
      exp_ctrl[k] = {(k >= 1 && k <= exp_done), rd[k], rd[k],
                     (k >= 1) ? rd[k-1] : 1'b0, (k == 1),
                     (k - 1 - PL >= 0) ? rd[k-1-PL] : 1'b0, (k == exp_done)};
      if (rst_cyc > 0 && k > rst_cyc) exp_ctrl[k] = 7'd0;
    end
  endtask

  // Drives one job (start in cycle 0) and records outputs for cycles 1..ncyc.
  // Inputs driven during cycle k are sampled at the edge opening cycle k+1.
  task automatic run_job(input int n, input logic [7:0] nb, input logic [7:0] wb,
                         input logic [63:0] pm, input int rst_cyc, input int ncyc,
                         input bit junk);
    @(posedge clk); #1;
    start = 1'b1;
    vec_len = 16'(n);
    neuron_base = nb;
    weight_base = wb;
    pause = pm[1];
    rst = 1'b0;
    obs_done_cyc = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = (junk && k < ncyc && (rst_cyc == 0 || k < rst_cyc)) ? 1'($urandom_range(0, 1)) : 1'b0;
      vec_len = 16'($urandom);
      neuron_base = 8'($urandom);
      weight_base = 8'($urandom);
      pause = pm[k+1];
      rst = (k == rst_cyc);
      @(negedge clk);
      obs_ctrl[k] = {busy, nram_rd_en, wram_rd_en, pe_vld, acc_clr, acc_en, done};
      obs_na[k] = nram_addr;
      obs_wa[k] = wram_addr;
      if (done && obs_done_cyc == 0) obs_done_cyc = k;
    end
    rst = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, nram_rd_en, wram_rd_en, pe_vld, acc_clr, acc_en, done} !== 7'd0
        || nram_addr !== 8'd0 || wram_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: ctrl=%b na=%h wa=%h, expected all zero",
               {busy, nram_rd_en, wram_rd_en, pe_vld, acc_clr, acc_en, done}, nram_addr, wram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, nram_rd_en, acc_clr, acc_en, done} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_idle: ctrl=%b expected 00000", {busy, nram_rd_en, acc_clr, acc_en, done});
    end
  endtask

  task automatic test_basic();
    model_job(4, 8'h10, 8'h80, 64'd0, 0);
    run_job(4, 8'h10, 8'h80, 64'd0, 0, exp_done + 1, 1'b0);
    for (int k = 1; k <= exp_done + 1; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k] || (exp_ctrl[k][5] && (obs_na[k] !== exp_na[k] || obs_wa[k] !== exp_wa[k]))) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got %b/%h/%h expected %b/%h/%h", k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k], exp_na[k], exp_wa[k]);
      end
    end
    n_cmp++;
    if (obs_done_cyc !== 8) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d expected 8", obs_done_cyc);
    end
  endtask

  task automatic test_zero_len();
    model_job(0, 8'h33, 8'h44, 64'd0, 0);
    run_job(0, 8'h33, 8'h44, 64'd0, 0, exp_done + 1, 1'b1);
    for (int k = 1; k <= exp_done + 1; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k]) begin
        n_fail++;
        $display("FAIL zero_len cyc %0d: got %b expected %b", k, obs_ctrl[k], exp_ctrl[k]);
      end
    end
    n_cmp++;
    if (obs_done_cyc !== 4) begin
      n_fail++;
      $display("FAIL zero_len_done_cycle: got %0d expected 4", obs_done_cyc);
    end
  endtask

  task automatic test_pause();
    logic [63:0] pm;
    pm = 64'd0;
    pm[2] = 1'b1;
    pm[3] = 1'b1;
    model_job(3, 8'h20, 8'h60, pm, 0);
    run_job(3, 8'h20, 8'h60, pm, 0, exp_done + 1, 1'b0);
    for (int k = 1; k <= exp_done + 1; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k] || (exp_ctrl[k][5] && (obs_na[k] !== exp_na[k] || obs_wa[k] !== exp_wa[k]))) begin
        n_fail++;
        $display("FAIL pause cyc %0d: got %b/%h/%h expected %b/%h/%h", k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k], exp_na[k], exp_wa[k]);
      end
    end
    n_cmp++;
    if (obs_done_cyc !== 9) begin
      n_fail++;
      $display("FAIL pause_done_cycle: got %0d expected 9", obs_done_cyc);
    end
  endtask

  task automatic test_wrap();
    model_job(4, 8'hFE, 8'hFF, 64'd0, 0);
    run_job(4, 8'hFE, 8'hFF, 64'd0, 0, exp_done + 1, 1'b0);
    for (int k = 1; k <= exp_done + 1; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k] || (exp_ctrl[k][5] && (obs_na[k] !== exp_na[k] || obs_wa[k] !== exp_wa[k]))) begin
        n_fail++;
        $display("FAIL wrap cyc %0d: got %b/%h/%h expected %b/%h/%h", k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k], exp_na[k], exp_wa[k]);
      end
    end
    n_cmp++;
    if (obs_na[3] !== 8'h00 || obs_na[4] !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h,%h expected 00,01", obs_na[3], obs_na[4]);
    end
  endtask

  task automatic test_reset_busy_start();
    model_job(4, 8'h10, 8'h80, 64'd0, 3);
    run_job(4, 8'h10, 8'h80, 64'd0, 3, 12, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k] || (k >= 4 && (obs_na[k] !== 8'd0 || obs_wa[k] !== 8'd0))) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %b/%h/%h expected %b", k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k]);
      end
    end
    n_cmp++;
    if (obs_done_cyc !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: done seen at cycle %0d expected none", obs_done_cyc);
    end
    model_job(4, 8'h10, 8'h80, 64'd0, 0);
    run_job(4, 8'h10, 8'h80, 64'd0, 0, exp_done + 1, 1'b1);
    for (int k = 1; k <= exp_done + 1; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k] || (exp_ctrl[k][5] && (obs_na[k] !== exp_na[k] || obs_wa[k] !== exp_wa[k]))) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %b/%h/%h expected %b/%h/%h", k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k], exp_na[k], exp_wa[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cnt;
    model_job(4, 8'h10, 8'h80, 64'd0, 0);
    run_job(4, 8'h10, 8'h80, 64'd0, 0, exp_done, 1'b0);
    for (int k = 1; k <= exp_done; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k]) begin
        n_fail++;
        $display("FAIL b2b_job1 cyc %0d: got %b expected %b", k, obs_ctrl[k], exp_ctrl[k]);
      end
    end
    model_job(5, 8'hA0, 8'h05, 64'd0, 0);
    run_job(5, 8'hA0, 8'h05, 64'd0, 0, exp_done + 1, 1'b0);
    acc_cnt = 0;
    for (int k = 1; k <= exp_done + 1; k++) begin
      n_cmp++;
      if (obs_ctrl[k] !== exp_ctrl[k] || (exp_ctrl[k][5] && (obs_na[k] !== exp_na[k] || obs_wa[k] !== exp_wa[k]))) begin
        n_fail++;
        $display("FAIL b2b_job2 cyc %0d: got %b/%h/%h expected %b/%h/%h", k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k], exp_na[k], exp_wa[k]);
      end
      if (obs_ctrl[k][1]) acc_cnt++;
    end
    n_cmp++;
    if (acc_cnt !== 5) begin
      n_fail++;
      $display("FAIL b2b_acc_count: got %0d expected 5", acc_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] nb, wb;
    logic [63:0] pm;
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(0, 12);
      nb = 8'($urandom);
      wb = 8'($urandom);
      pm = 64'd0;
      for (int i = 2; i <= 30; i++) pm[i] = ($urandom_range(0, 9) < 3);
      model_job(n, nb, wb, pm, 0);
      run_job(n, nb, wb, pm, 0, exp_done + 1, 1'b1);
      for (int k = 1; k <= exp_done + 1; k++) begin
        n_cmp++;
        if (obs_ctrl[k] !== exp_ctrl[k] || (exp_ctrl[k][5] && (obs_na[k] !== exp_na[k] || obs_wa[k] !== exp_wa[k]))) begin
          n_fail++;
          $display("FAIL random job %0d n=%0d cyc %0d: got %b/%h/%h expected %b/%h/%h", j, n, k, obs_ctrl[k], obs_na[k], obs_wa[k], exp_ctrl[k], exp_na[k], exp_wa[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_pause();
    test_wrap();
    test_reset_busy_start();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
